// File: rtl/router_odata_arbiter_pkg.sv
// router_odata_pkg: shared types and default sizing for the ODATA output arbiter.
// Holds the FSM state enum, the default parameters and the derived widths.
package router_odata_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int CREDITS_DEF = 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W = idx_w(NUM_REQ_DEF);
  localparam int CRD_W = $clog2(CREDITS_DEF + 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

endpackage

// File: rtl/router_odata_arbiter_if.sv
// router_odata_arbiter_if: requester flits + downstream credit/ODATA bundle.
// slave = arbiter side, master = requesters/downstream side.
interface router_odata_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_head;
  logic [NUM_REQ-1:0]        req_tail;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         odata;
  logic                      odata_valid;
  logic                      odata_head;
  logic                      odata_tail;
  logic                      credit_in;
  logic                      credit_err;

  modport slave (
    input  req_valid, req_head, req_tail, req_data, credit_in,
    output req_ready, odata, odata_valid, odata_head, odata_tail,
    output credit_err
  );

  modport master (
    output req_valid, req_head, req_tail, req_data, credit_in,
    input  req_ready, odata, odata_valid, odata_head, odata_tail,
    input  credit_err
  );
endinterface

// File: rtl/router_odata_arbiter_rr.sv
// rr_arbiter_nreq: combinational round-robin pick starting at ptr_i.
// eligible_i/ptr_i in; onehot grant_o, index idx_o, any_o out.
module rr_arbiter_nreq #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  eligible_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  int k;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    k       = 0;
    for (int off = 0; off < N; off++) begin
      k = (int'(ptr_i) + off) % N;
      if (!any_o && eligible_i[k]) begin
        any_o      = 1'b1;
        idx_o      = IW'(k);
        grant_o[k] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/router_odata_arbiter.sv
// router_odata_arbiter: wormhole output scheduler, RR on heads, credit flow.
// Ports: clk, reset (async active-low), bus (slave modport).
module router_odata_arbiter
  import router_odata_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CREDITS = CREDITS_DEF
) (
  input logic clk,
  input logic reset,
  router_odata_arbiter_if.slave bus
);
  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = $clog2(CREDITS + 1);

  state_e            state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [CW-1:0]     crd_q;
  logic              err_q;
  logic [DATA_W-1:0] odata_q;
  logic              vld_q, head_q, tail_q;

  logic [NUM_REQ-1:0] elig, gnt;
  logic [IW-1:0]      gidx, sel;
  logic               any, can_send, xfer;

  assign elig     = bus.req_valid & bus.req_head;
  assign can_send = (crd_q != '0);

  rr_arbiter_nreq #(.N(NUM_REQ), .IW(IW)) u_rr (
    .eligible_i (elig),
    .ptr_i      (rr_q),
    .grant_o    (gnt),
    .idx_o      (gidx),
    .any_o      (any)
  );

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_d          = rr_q;
    bus.req_ready = '0;
    sel           = gidx;
    xfer          = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = can_send ? gnt : '0;
        xfer          = any & can_send;
        if (xfer) begin
          rr_d = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
          if (!bus.req_tail[gidx]) begin
            state_d = LOCKED;
            owner_d = gidx;
          end
        end
      end
      LOCKED: begin
        sel  = owner_q;
        xfer = can_send & bus.req_valid[owner_q];
        bus.req_ready[owner_q] = xfer;
        if (xfer && bus.req_tail[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  // Simultaneous launch and credit return cancel out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crd_q <= CW'(CREDITS);
      err_q <= 1'b0;
    end else begin
      case ({xfer, bus.credit_in})
        2'b10: crd_q <= crd_q - 1'b1;
        2'b01: begin
          if (crd_q == CW'(CREDITS)) err_q <= 1'b1;
          else crd_q <= crd_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      odata_q <= '0;
      vld_q   <= 1'b0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
    end else begin
      vld_q <= xfer;
      if (xfer) begin
        odata_q <= bus.req_data[sel*DATA_W +: DATA_W];
        head_q  <= bus.req_head[sel];
        tail_q  <= bus.req_tail[sel];
      end
    end
  end

  assign bus.odata       = odata_q;
  assign bus.odata_valid = vld_q;
  assign bus.odata_head  = head_q;
  assign bus.odata_tail  = tail_q;
  assign bus.credit_err  = err_q;
endmodule

// File: tb/tb_router_odata_arbiter.sv
// tb_router_odata_arbiter: directed vectors for router_odata_arbiter.
// Hand-computed expectations for grant, ODATA and credit behaviour.
module tb_router_odata_arbiter;
  import router_odata_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  logic [CRD_W-1:0] full_crd;
  logic [IDX_W-1:0] last_idx;

  always #5 clk = ~clk;

  router_odata_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

  router_odata_arbiter #(
    .NUM_REQ(4), .DATA_W(8), .CREDITS(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clr();
    bus.req_valid = '0;
    bus.req_head  = '0;
    bus.req_tail  = '0;
    bus.req_data  = '0;
    bus.credit_in = 1'b0;
  endtask

  task automatic put(input int i, input logic h, input logic t,
                     input logic [7:0] d);
    bus.req_valid[i]     = 1'b1;
    bus.req_head[i]      = h;
    bus.req_tail[i]      = t;
    bus.req_data[i*8+:8] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic crd(input string tag, input int exp);
    chk(tag, 32'(dut.crd_q), exp);
  endtask

  task automatic out(input string tag, input logic [7:0] d,
                     input logic v, input logic h, input logic t);
    chk({tag, "_data"}, 32'(bus.odata), 32'(d));
    chk({tag, "_vht"}, {29'd0, bus.odata_valid, bus.odata_head,
        bus.odata_tail}, {29'd0, v, h, t});
  endtask

  initial begin
    full_crd = CRD_W'(4);
    last_idx = IDX_W'(3);
    clr();
    #12;
    out("rst", 8'h00, 0, 0, 0);
    chk("rst_err", 32'(bus.credit_err), 0);
    crd("rst_crd", 32'(full_crd));
    reset = 1'b1;
    step();

    // 1: single-flit packet on req0
    put(0, 1, 1, 8'hA5);
    settle();
    chk("t1_rdy", 32'(bus.req_ready), 32'h1);
    step();
    clr();
    out("t1_out", 8'hA5, 1, 1, 1);
    crd("t1_crd", 3);
    step();
    out("t1_hold", 8'hA5, 0, 1, 1);

    // 2: rr_ptr=1, req1 beats req2, req2 blocked during packet
    put(1, 1, 0, 8'h11);
    put(2, 1, 1, 8'h99);
    settle();
    chk("t2_rdy0", 32'(bus.req_ready), 32'h2);
    step();
    out("t2_f0", 8'h11, 1, 1, 0);
    crd("t2_crd0", 2);
    put(1, 0, 0, 8'h22);
    bus.credit_in = 1'b1;
    settle();
    chk("t2_rdy1", 32'(bus.req_ready), 32'h2);
    step();
    out("t2_f1", 8'h22, 1, 0, 0);
    crd("t4_same_cyc", 2);
    put(1, 0, 1, 8'h33);
    settle();
    chk("t2_rdy2", 32'(bus.req_ready), 32'h2);
    step();
    out("t2_f2", 8'h33, 1, 0, 1);
    crd("t2_crd2", 2);
    bus.credit_in = 1'b0;
    bus.req_valid[1] = 1'b0;
    settle();
    chk("t2_rdy3", 32'(bus.req_ready), 32'h4);
    step();
    clr();
    out("t2_f3", 8'h99, 1, 1, 1);
    crd("t2_crd3", 1);

    // 4: refill then overflow sets sticky error
    bus.credit_in = 1'b1;
    repeat (3) step();
    crd("t4_full", 4);
    chk("t4_err0", 32'(bus.credit_err), 0);
    step();
    bus.credit_in = 1'b0;
    crd("t4_sat", 4);
    chk("t4_err1", 32'(bus.credit_err), 1);
    step();
    chk("t4_err2", 32'(bus.credit_err), 1);

    // 3: five flits from req3, credits run out after four
    for (int f = 0; f < 4; f++) begin
      put(3, f == 0, 0, 8'(8'h30 + f));
      settle();
      chk($sformatf("t3_rdy%0d", f), 32'(bus.req_ready), 32'h8);
      step();
      out($sformatf("t3_f%0d", f), 8'(8'h30 + f), 1, f == 0, 0);
    end
    crd("t3_empty", 0);
    put(3, 0, 1, 8'h34);
    settle();
    chk("t3_rdy_blk", 32'(bus.req_ready), 32'h0);
    bus.credit_in = 1'b1;
    step();
    bus.credit_in = 1'b0;
    chk("t3_vld_blk", 32'(bus.odata_valid), 0);
    crd("t3_crd1", 1);
    settle();
    chk("t3_rdy_go", 32'(bus.req_ready), 32'h8);
    step();
    clr();
    out("t3_f4", 8'h34, 1, 0, 1);
    crd("t3_crd0", 0);
    bus.credit_in = 1'b1;
    repeat (4) step();
    bus.credit_in = 1'b0;
    crd("t3_refill", 4);

    // 5: owner req0 stalls, req3 head must wait (rr_ptr=0)
    put(0, 1, 0, 8'h50);
    settle();
    chk("t5_rdy0", 32'(bus.req_ready), 32'h1);
    step();
    out("t5_f0", 8'h50, 1, 1, 0);
    clr();
    put(3, 1, 1, 8'h3F);
    for (int c = 0; c < 3; c++) begin
      settle();
      chk($sformatf("t5_stall%0d", c), 32'(bus.req_ready), 32'h0);
      step();
      chk($sformatf("t5_vld%0d", c), 32'(bus.odata_valid), 0);
    end
    put(0, 0, 1, 8'h51);
    settle();
    chk("t5_rdy_tail", 32'(bus.req_ready), 32'h1);
    step();
    out("t5_tail", 8'h51, 1, 0, 1);
    bus.req_valid[0] = 1'b0;
    settle();
    chk("t5_rdy3", 32'(bus.req_ready), 32'h8);
    step();
    clr();
    out("t5_r3", 8'h3F, 1, 1, 1);
    crd("t5_crd", 1);

    // 6: reset while LOCKED with one credit left
    bus.credit_in = 1'b1;
    step();
    bus.credit_in = 1'b0;
    put(2, 1, 0, 8'h77);
    step();
    clr();
    crd("t6_crd1", 1);
    put(0, 1, 1, 8'h01);
    settle();
    chk("t6_locked", 32'(bus.req_ready), 32'h0);
    reset = 1'b0;
    settle();
    out("t6_rst", 8'h00, 0, 0, 0);
    crd("t6_crd4", 32'(full_crd));
    chk("t6_err", 32'(bus.credit_err), 0);
    step();
    reset = 1'b1;
    clr();
    put(3, 1, 1, 8'hC3);
    settle();
    chk("t6_rdy", 32'(bus.req_ready), 32'(1) << last_idx);
    step();
    clr();
    out("t6_out", 8'hC3, 1, 1, 1);
    crd("t6_crd3", 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
